// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the uncached load/store unit.
//   state_t        : IDLE / BUS / DONE state encoding
//   SIZE_*         : access width derived from the RV32 funct3 code
//   F3_UNSIGNED    : funct3 bit that selects zero-extension on loads
//   ERR_*          : completion error codes reported on error_o
//   access_size()  : funct3 -> width, unknown codes collapse to word
//   is_misaligned(): natural-alignment check for a given width/address
// -----------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam int F3_UNSIGNED = 2;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_BUS      = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   // 011 and 11x are not legal RV32 load/store codes; treating them as word
   // keeps the datapath total without a separate illegal-op path.
   function automatic logic [1:0] access_size(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return SIZE_BYTE;
         2'b01:   return SIZE_HALF;
         default: return SIZE_WORD;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      case (access_size(funct3))
         SIZE_HALF: return addr_lo[0];
         SIZE_WORD: return (addr_lo != 2'b00);
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for a 32-bit Wishbone data path.
//   addr_lo   in  2   byte offset within the word
//   funct3    in  3   RV32 width/sign code
//   wdata     in  32  right-aligned store data
//   bus_rdata in  32  raw word returned by the bus
//   sel       out 4   byte enables for the access
//   bus_wdata out 32  store data replicated onto every lane of its width
//   rdata     out 32  load data shifted down and sign/zero extended
// -----------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  sel,
   output logic [31:0] bus_wdata,
   output logic [31:0] rdata
);

   logic [1:0]  size;
   logic [31:0] shifted;
   logic        sign_ext;

   assign size     = access_size(funct3);
   assign sign_ext = ~funct3[F3_UNSIGNED];

   // Replicating the data onto every lane means the slave only needs sel to
   // pick the right bytes; no per-offset data mux is required.
   always_comb begin
      // NOTE: outputs get defaults before the case so no path can infer a latch.
      sel       = 4'b1111;
      bus_wdata = wdata;
      case (size)
         SIZE_BYTE: begin
            sel       = 4'b0001 << addr_lo;
            bus_wdata = {4{wdata[7:0]}};
         end
         SIZE_HALF: begin
            sel       = 4'b0011 << addr_lo;
            bus_wdata = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign shifted = bus_rdata >> {addr_lo, 3'b000};

   always_comb begin
      rdata = shifted;
      case (size)
         SIZE_BYTE: rdata = {{24{sign_ext & shifted[7]}},  shifted[7:0]};
         SIZE_HALF: rdata = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_uncached.sv
// -----------------------------------------------------------------------------
// lsu_uncached
// Uncached MEM-stage load/store unit issuing single classic Wishbone cycles.
// Optional feature macro: LSU_BUS_TIMEOUT_EN (bus wait timeout, error 11).
//   clk, rst_i          core clock, synchronous active-high reset
//   load_i / store_i    request strobes from the region selector
//   addr_i / wdata_i    byte address and right-aligned store data
//   funct3_i            RV32 width/sign code
//   rdata_o             aligned, extended load result (holds after stores)
//   valid_o             one-cycle completion pulse
//   stall_o             pipeline hold while the access is outstanding
//   error_o             00 ok, 01 misaligned, 10 bus error, 11 timeout
//   wb_*                classic Wishbone master interface
// -----------------------------------------------------------------------------
module lsu_uncached
   import lsu_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic              clk,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              store_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [2:0]        funct3_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              valid_o,
   output logic              stall_o,
   output logic [1:0]        error_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   output logic [3:0]        wb_sel_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i
);

   state_t            state, state_nxt;
   logic [1:0]        err_q, err_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [2:0]        funct3_q;
   logic              we_q;

   logic              req;
   logic              accept;
   logic              in_bus;
   logic              timeout_hit;
   logic [3:0]        lane_sel;
   logic [DATA_W-1:0] lane_wdata;
   logic [DATA_W-1:0] lane_rdata;

   assign req    = load_i | store_i;
   assign accept = (state == S_IDLE) && req;
   assign in_bus = (state == S_BUS);

   lsu_align u_align (
      .addr_lo   (addr_q[1:0]),
      .funct3    (funct3_q),
      .wdata     (wdata_q),
      .bus_rdata (wb_dat_i),
      .sel       (lane_sel),
      .bus_wdata (lane_wdata),
      .rdata     (lane_rdata)
   );

`ifdef LSU_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;

   // Held at zero outside BUS, so it is already clear on every BUS entry.
   always_ff @(posedge clk) begin
      if (rst_i || !in_bus) begin
         wait_cnt <= '0;
      end else if (!wb_ack_i && !wb_err_i) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // The edge that would take the count to TIMEOUT_CYCLES ends the cycle.
   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (rst_i) begin
         state <= S_IDLE;
         err_q <= ERR_NONE;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (is_misaligned(funct3_i, addr_i[1:0])) begin
                  state_nxt = S_DONE;
                  err_nxt   = ERR_MISALIGN;
               end else begin
                  state_nxt = S_BUS;
                  err_nxt   = ERR_NONE;
               end
            end
         end
         S_BUS: begin
            // err outranks a simultaneous ack.
            if (wb_err_i) begin
               state_nxt = S_DONE;
               err_nxt   = ERR_BUS;
            end else if (wb_ack_i) begin
               state_nxt = S_DONE;
               err_nxt   = ERR_NONE;
            end else if (timeout_hit) begin
               state_nxt = S_DONE;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request fields are captured once at accept; the pipeline may change its
   // inputs after DONE, but the bus sees only these registered copies.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
      end else if (accept) begin
         addr_q   <= addr_i;
         wdata_q  <= wdata_i;
         funct3_q <= funct3_i;
         we_q     <= store_i;
      end
   end

   // Only a successful load updates the result; stores and errors leave it.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (in_bus && wb_ack_i && !wb_err_i && !we_q) begin
         rdata_q <= lane_rdata;
      end
   end

   assign wb_cyc_o = in_bus;
   assign wb_stb_o = in_bus;
   assign wb_we_o  = in_bus & we_q;
   assign wb_adr_o = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign wb_dat_o = in_bus ? lane_wdata : '0;
   assign wb_sel_o = in_bus ? lane_sel : 4'b0000;

   assign rdata_o  = rdata_q;
   assign valid_o  = (state == S_DONE);
   assign error_o  = (state == S_DONE) ? err_q : ERR_NONE;
   assign stall_o  = accept | in_bus;

endmodule

// File: tb/tb_lsu_uncached.sv
// -----------------------------------------------------------------------------
// tb_lsu_uncached
// Table-driven bench for lsu_uncached with a behavioural Wishbone slave and
// an expected-result queue. Honours LSU_BUS_TIMEOUT_EN for the timeout case.
// -----------------------------------------------------------------------------
module tb_lsu_uncached;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        load_i, store_i;
   logic [31:0] addr_i, wdata_i;
   logic [2:0]  funct3_i;
   logic [31:0] rdata_o;
   logic        valid_o, stall_o;
   logic [1:0]  error_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i, wb_err_i;

   always #5 clk = ~clk;

   lsu_uncached #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk      (clk),
      .rst_i    (rst_i),
      .load_i   (load_i),
      .store_i  (store_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .funct3_i (funct3_i),
      .rdata_o  (rdata_o),
      .valid_o  (valid_o),
      .stall_o  (stall_o),
      .error_o  (error_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_sel_o (wb_sel_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i),
      .wb_err_i (wb_err_i)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // ---------------- behavioural slave ----------------
   int          slave_wait = 0;
   logic        slave_err  = 1'b0;
   logic [31:0] slave_data = '0;
   logic        ack_slave  = 1'b0;
   logic        err_slave  = 1'b0;
   logic        ack_manual = 1'b0;
   int          bus_starts = 0;
   logic        bus_unstable = 1'b0;
   logic        in_txn = 1'b0;
   int          wcnt = 0;
   logic [31:0] obs_adr, obs_dat;
   logic [3:0]  obs_sel;
   logic        obs_we;

   assign wb_dat_i = slave_data;
   assign wb_ack_i = ack_slave | ack_manual;
   assign wb_err_i = err_slave;

   always @(negedge clk) begin
      if (wb_cyc_o && wb_stb_o) begin
         if (!in_txn) begin
            in_txn = 1'b1;
            bus_starts++;
            obs_adr = wb_adr_o;
            obs_dat = wb_dat_o;
            obs_sel = wb_sel_o;
            obs_we  = wb_we_o;
            wcnt    = 0;
         end else if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== {obs_adr, obs_dat, obs_sel, obs_we}) begin
            bus_unstable = 1'b1;
         end
         if (wcnt == slave_wait) begin
            ack_slave = 1'b1;
            err_slave = slave_err;
         end else begin
            ack_slave = 1'b0;
            err_slave = 1'b0;
            wcnt++;
         end
      end else begin
         in_txn    = 1'b0;
         ack_slave = 1'b0;
         err_slave = 1'b0;
      end
   end

   // ---------------- vectors and scoreboard ----------------
   typedef struct {
      logic        ld;
      logic        st;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      int          waits;
      logic        berr;
      logic [31:0] bdata;
      logic [1:0]  exp_err;
      logic [31:0] exp_rdata;
      logic        exp_cyc;
      logic [3:0]  exp_sel;
      logic [31:0] exp_dat;
      int          exp_cycle;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs[NVEC];
   vec_t sb_q[$];

   task automatic drive_req(input logic ld, input logic st, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3);
      load_i   = ld;
      store_i  = st;
      addr_i   = addr;
      wdata_i  = wdata;
      funct3_i = f3;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      vec_t e;
      int   c;
      bit   seen;
      v = vecs[idx];
      sb_q.push_back(v);
      slave_wait   = v.waits;
      slave_err    = v.berr;
      slave_data   = v.bdata;
      bus_starts   = 0;
      bus_unstable = 1'b0;
      drive_req(v.ld, v.st, v.addr, v.wdata, v.f3);
      c    = 1;
      seen = 1'b0;
      while (!seen && c < 40) begin
         @(negedge clk);
         c++;
         if (valid_o) begin
            seen = 1'b1;
            e = sb_q.pop_front();
            check($sformatf("v%0d error", idx), 32'(error_o), 32'(e.exp_err));
            check($sformatf("v%0d rdata", idx), rdata_o, e.exp_rdata);
            check($sformatf("v%0d valid_cycle", idx), 32'(c), 32'(e.exp_cycle));
            check($sformatf("v%0d done_cyc_stall", idx), {30'd0, wb_cyc_o, stall_o}, 32'd0);
            if (e.exp_cyc) begin
               check($sformatf("v%0d adr", idx), obs_adr, e.addr & 32'hFFFF_FFFC);
               check($sformatf("v%0d sel", idx), 32'(obs_sel), 32'(e.exp_sel));
               check($sformatf("v%0d we", idx), 32'(obs_we), 32'(e.st));
               check($sformatf("v%0d bus_stable", idx), 32'(bus_unstable), 32'd0);
               if (e.st) check($sformatf("v%0d dat", idx), obs_dat, e.exp_dat);
            end
         end
      end
      if (!seen) begin
         check($sformatf("v%0d valid_seen", idx), 32'd0, 32'd1);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      // Request stayed up through DONE; release it now.
      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      check($sformatf("v%0d post_valid_err", idx), {29'd0, valid_o, error_o}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d bus_starts", idx), 32'(bus_starts), 32'(v.exp_cyc));
      check($sformatf("v%0d idle_cyc", idx), 32'(wb_cyc_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   c;
      bit   seen;
      logic got_valid;
      int   hold_n;

      //            ld st addr           wdata          f3     w  be bdata          err    rdata          cyc sel     dat           cyc#
      vecs[0]  = '{1'b0,1'b1,32'h8000_0004,32'hDEAD_BEEF,3'b010,2,1'b0,32'h0000_0000,2'b00,32'h0000_0000,1'b1,4'b1111,32'hDEAD_BEEF,5};
      vecs[1]  = '{1'b1,1'b0,32'h8000_0003,32'h0000_0000,3'b000,0,1'b0,32'h80FF_FF7F,2'b00,32'hFFFF_FF80,1'b1,4'b1000,32'h0000_0000,3};
      vecs[2]  = '{1'b1,1'b0,32'h8000_0003,32'h0000_0000,3'b100,0,1'b0,32'h80FF_FF7F,2'b00,32'h0000_0080,1'b1,4'b1000,32'h0000_0000,3};
      vecs[3]  = '{1'b1,1'b0,32'h8000_0001,32'h0000_0000,3'b001,0,1'b0,32'h0000_0000,2'b01,32'h0000_0080,1'b0,4'b0000,32'h0000_0000,2};
      vecs[4]  = '{1'b0,1'b1,32'h8000_0012,32'h0000_1234,3'b001,1,1'b0,32'h0000_0000,2'b00,32'h0000_0080,1'b1,4'b1100,32'h1234_1234,4};
      vecs[5]  = '{1'b1,1'b0,32'h8000_0020,32'h0000_0000,3'b010,0,1'b1,32'h1111_2222,2'b10,32'h0000_0080,1'b1,4'b1111,32'h0000_0000,3};
      vecs[6]  = '{1'b1,1'b0,32'h8000_0002,32'h0000_0000,3'b001,0,1'b0,32'h8001_7FFF,2'b00,32'hFFFF_8001,1'b1,4'b1100,32'h0000_0000,3};
      vecs[7]  = '{1'b1,1'b0,32'h8000_0000,32'h0000_0000,3'b101,0,1'b0,32'h1234_F00D,2'b00,32'h0000_F00D,1'b1,4'b0011,32'h0000_0000,3};
      vecs[8]  = '{1'b1,1'b0,32'h8000_0008,32'h0000_0000,3'b010,3,1'b0,32'hCAFE_BABE,2'b00,32'hCAFE_BABE,1'b1,4'b1111,32'h0000_0000,6};
      vecs[9]  = '{1'b0,1'b1,32'h8000_0001,32'h1234_56A5,3'b000,0,1'b0,32'h0000_0000,2'b00,32'hCAFE_BABE,1'b1,4'b0010,32'hA5A5_A5A5,3};
      vecs[10] = '{1'b0,1'b1,32'h8000_0002,32'h1122_3344,3'b010,0,1'b0,32'h0000_0000,2'b01,32'hCAFE_BABE,1'b0,4'b0000,32'h0000_0000,2};
      vecs[11] = '{1'b1,1'b0,32'h8000_0001,32'h0000_0000,3'b000,0,1'b0,32'h0000_7F00,2'b00,32'h0000_007F,1'b1,4'b0010,32'h0000_0000,3};
      vecs[12] = '{1'b1,1'b0,32'h8000_0004,32'h0000_0000,3'b110,1,1'b0,32'h89AB_CDEF,2'b00,32'h89AB_CDEF,1'b1,4'b1111,32'h0000_0000,4};
      vecs[13] = '{1'b1,1'b1,32'h8000_000C,32'h0102_0304,3'b010,0,1'b0,32'h0000_0000,2'b00,32'h89AB_CDEF,1'b1,4'b1111,32'h0102_0304,3};
      vecs[14] = '{1'b1,1'b0,32'h8000_0003,32'h0000_0000,3'b101,0,1'b0,32'h0000_0000,2'b01,32'h89AB_CDEF,1'b0,4'b0000,32'h0000_0000,2};
      vecs[15] = '{1'b0,1'b1,32'h8000_0005,32'h0000_00EE,3'b000,1,1'b1,32'h0000_0000,2'b10,32'h89AB_CDEF,1'b1,4'b0010,32'hEEEE_EEEE,4};

      rst_i = 1'b1;
      drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      repeat (3) @(negedge clk);
      check("reset ctrl", {22'd0, valid_o, stall_o, error_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 32'd0);
      check("reset rdata", rdata_o, 32'd0);
      check("reset adr_dat", wb_adr_o | wb_dat_o, 32'd0);
      rst_i = 1'b0;
      @(negedge clk);
      check("post_reset idle", {28'd0, valid_o, stall_o, wb_cyc_o, wb_stb_o}, 32'd0);

      for (int i = 0; i < NVEC; i++) run_vec(i);

      // Reset in the middle of a bus cycle that never acks.
`ifdef LSU_BUS_TIMEOUT_EN
      hold_n = 3;
`else
      hold_n = 12;
`endif
      slave_wait = 1000;
      slave_err  = 1'b0;
      slave_data = 32'h5555_AAAA;
      drive_req(1'b1, 1'b0, 32'h8000_0010, 32'd0, 3'b010);
      got_valid = 1'b0;
      for (int i = 0; i < hold_n; i++) begin
         @(negedge clk);
         if (valid_o) got_valid = 1'b1;
      end
      check("hold cyc_stb_stall", {29'd0, wb_cyc_o, wb_stb_o, stall_o}, 32'd7);
      check("hold no_valid", 32'(got_valid), 32'd0);
      rst_i = 1'b1;
      drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      @(negedge clk);
      check("midbus_reset cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
      check("midbus_reset rdata", rdata_o, 32'd0);
      rst_i      = 1'b0;
      ack_manual = 1'b1;
      @(negedge clk);
      ack_manual = 1'b0;
      got_valid  = valid_o;
      repeat (4) begin
         @(negedge clk);
         if (valid_o) got_valid = 1'b1;
      end
      check("late_ack no_valid", 32'(got_valid), 32'd0);
      check("late_ack idle", {29'd0, stall_o, wb_cyc_o, error_o != 2'b00}, 32'd0);

`ifdef LSU_BUS_TIMEOUT_EN
      // No ack at all: four BUS cycles then DONE with timeout.
      bus_starts = 0;
      drive_req(1'b1, 1'b0, 32'h8000_0040, 32'd0, 3'b010);
      c    = 1;
      seen = 1'b0;
      while (!seen && c < 40) begin
         @(negedge clk);
         c++;
         if (valid_o) begin
            seen = 1'b1;
            check("timeout error", 32'(error_o), 32'd3);
            check("timeout cycle", 32'(c), 32'd6);
            check("timeout cyc_low", 32'(wb_cyc_o), 32'd0);
            check("timeout rdata", rdata_o, 32'd0);
         end
      end
      if (!seen) check("timeout valid_seen", 32'd0, 32'd1);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      @(negedge clk);
      check("timeout bus_starts", 32'(bus_starts), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_uncached.md
Name: lsu_uncached

Overview:
- Uncached load/store unit in the MEM stage.
- Sits directly downstream of the cacheable-region selector and consumes its lsu_load/lsu_store strobes.
- Performs single, non-burst Wishbone-style (classic) bus transactions to peripherals and non-cacheable memory, including byte-lane steering and sign extension.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum number of wait cycles for an ack (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- load_i  in  1  uncached load request, from the region selector.
- store_i  in  1  uncached store request, from the region selector.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned.
- funct3_i  in  3  RV32 width/sign code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- rdata_o  out  32  aligned, extended load result.
- valid_o  out  1  one-cycle completion pulse.
- stall_o  out  1  holds the pipeline.
- error_o  out  2  00 ok, 01 misaligned, 10 bus error, 11 timeout.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  bus strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  32  word address, bits [1:0] forced to 0.
- wb_dat_o  out  32  lane-shifted write data.
- wb_sel_o  out  4  byte enables.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  transfer acknowledge.
- wb_err_i  in  1  bus error.

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0, and rdata_o is 0.
  - A reset during BUS deasserts cyc/stb at that same edge. A later ack is ignored.
- Only one of load_i/store_i may be high at a time. If both are high, the request is treated as a store.
- FSM states are IDLE, BUS, DONE.
- IDLE, on request (load_i|store_i):
  - Register addr, wdata, funct3 and we.
  - Misalignment check: halfword with addr[0]=1, or word with addr[1:0]≠00.
    - If misaligned: go to DONE with error 01. No bus cycle is issued.
    - Otherwise: go to BUS.
- BUS:
  - cyc, stb, we, adr, dat and sel are driven from the registered values and held stable until termination.
  - ack → DONE. For a load, capture wb_dat_i at that edge.
  - err → DONE with error 10. If ack and err arrive together, err wins.
- DONE:
  - valid_o = 1 and stall_o = 0 for exactly one cycle.
  - error_o is valid in this cycle and 0 otherwise.
  - Unconditionally return to IDLE. A request still present in this cycle is not re-accepted.
- stall_o = (load_i|store_i) in IDLE, or state==BUS. It is 0 in DONE.
- The pipeline holds its inputs stable while stall_o is 1.
- Latency:
  - Minimum 3 cycles from request to valid: accept, 1 bus cycle with immediate ack, DONE.
  - Misaligned access: 2 cycles.
- Write lanes:
  - byte: sel = 0001<<addr[1:0], dat = {4{wdata[7:0]}}.
  - half: sel = 0011<<addr[1:0], dat = {2{wdata[15:0]}}.
  - word: sel = 1111.
- Read:
  - Shift the captured data right by addr[1:0]*8.
  - Sign-extend or zero-extend per funct3[2].
- Store completion: valid_o pulses, and rdata_o holds its last value.
- Unknown funct3 codes (011, 11x) are treated as word width.

Optional Feature:
- Macro: LSU_BUS_TIMEOUT_EN.
- When defined:
  - An 8+-bit wait counter, sized $clog2(TIMEOUT_CYCLES+1), clears on entry to BUS and increments each BUS cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES, cyc/stb drop and the FSM goes to DONE with error 11.
- When undefined: no counter exists, BUS waits indefinitely, and code 11 is never produced.

Decomposition:
- Package lsu_pkg holds:
  - the state enum (IDLE/BUS/DONE);
  - funct3 width localparams;
  - the error code localparams (ERR_NONE/MISALIGN/BUS/TIMEOUT).
- Sub-module lsu_align is purely combinational and provides the sel/wdata generation and the read shift/extend. It is instantiated once.

Test Plan:
- SW of 0xDEADBEEF to 0x8000_0004, ack after 2 wait cycles:
  - adr=0x8000_0004, sel=1111, we=1.
  - valid on cycle 5, error=00.
- LB from 0x8000_0003, wb_dat_i=0x80FF_FF7F:
  - sel=1000, rdata=0xFFFF_FF80.
  - The same access as LBU gives 0x0000_0080.
- LH from 0x8000_0001:
  - no cyc.
  - valid the next cycle, error=01.
- SH of 0x1234 to addr[1:0]=10:
  - sel=1100, dat=0x1234_1234.
- LW with err and ack in the same cycle:
  - error=10.
  - cyc low in DONE.
  - Request held through DONE; no second bus cycle.
- Reset asserted mid-BUS:
  - cyc/stb=0 the next cycle.
  - A late ack produces no valid.
  - With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no ack: error=11 after 4 BUS cycles.
